// File: rtl/register_file.sv
// register_file: 32 x 32-bit architectural register file with one write port
// and two independent combinational read ports. Entry 0 always reads as zero.
// A write to the register being read in the same cycle is forwarded straight
// to the read port, so decode sees the value being written back.
module register_file #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     read_enable_a,
    input  logic [ADDRESS_WIDTH-1:0] read_address_a,
    output logic [DATA_WIDTH-1:0]    read_data_a,
    input  logic                     read_enable_b,
    input  logic [ADDRESS_WIDTH-1:0] read_address_b,
    output logic [DATA_WIDTH-1:0]    read_data_b
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] entries [DEPTH];

    logic write_active;

    // A write only commits when the file is out of reset and the target is not r0.
    always_comb begin
        write_active = reset && write_enable && (write_address != '0);
    end

    // Storage update: reset clears every entry and swallows any write that cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (write_active) begin
            entries[write_address] <= write_data;
        end
    end

    // Port A read: reset, enable and r0 force zero; a matching write is bypassed.
    always_comb begin
        read_data_a = '0;
        if (!reset || !read_enable_a || (read_address_a == '0)) begin
            read_data_a = '0;
        end else if (write_enable && (write_address == read_address_a)) begin
            read_data_a = write_data;
        end else begin
            read_data_a = entries[read_address_a];
        end
    end

    // Port B read: identical rules to port A, fully independent of it.
    always_comb begin
        read_data_b = '0;
        if (!reset || !read_enable_b || (read_address_b == '0)) begin
            read_data_b = '0;
        end else if (write_enable && (write_address == read_address_b)) begin
            read_data_b = write_data;
        end else begin
            read_data_b = entries[read_address_b];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed stimulus with hand-computed expectations, plus a
// behavioural register-file model checked against both read ports every cycle.
module tb_register_file;

    logic        clock;
    logic        reset;
    logic        write_enable;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic        read_enable_a;
    logic [4:0]  read_address_a;
    logic [31:0] read_data_a;
    logic        read_enable_b;
    logic [4:0]  read_address_b;
    logic [31:0] read_data_b;

    int check_count = 0;
    int pass_count  = 0;

    logic [31:0] model_regs [32];
    bit          seen_reset = 0;

    register_file #(
        .DATA_WIDTH   (32),
        .ADDRESS_WIDTH(5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .read_enable_a (read_enable_a),
        .read_address_a(read_address_a),
        .read_data_a   (read_data_a),
        .read_enable_b (read_enable_b),
        .read_address_b(read_address_b),
        .read_data_b   (read_data_b)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Expected read value straight from the read rules, in priority order.
    function automatic logic [31:0] model_read(input logic en, input logic [4:0] addr);
        if (!reset) return 32'h0;
        if (!en) return 32'h0;
        if (addr == 5'd0) return 32'h0;
        if (write_enable && (write_address == addr)) return write_data;
        return model_regs[addr];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at time %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs just after a rising edge, then let reads settle.
    task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic ea, input logic [4:0] aa,
                                 input logic eb, input logic [4:0] ab);
        @(posedge clock);
        #1;
        reset          = rst;
        write_enable   = we;
        write_address  = wa;
        write_data     = wd;
        read_enable_a  = ea;
        read_address_a = aa;
        read_enable_b  = eb;
        read_address_b = ab;
        #1;
    endtask

    // Model state update on each rising edge, from the inputs held across it.
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
            seen_reset = 1;
        end else if (write_enable && (write_address != 5'd0)) begin
            model_regs[write_address] = write_data;
        end
    end

    // Compare both ports against the model mid-cycle once the file is defined.
    always @(negedge clock) begin
        if (seen_reset || !reset) begin
            checkOutput("model_port_a", read_data_a, model_read(read_enable_a, read_address_a));
            checkOutput("model_port_b", read_data_b, model_read(read_enable_b, read_address_b));
        end
    end

    initial begin
        reset          = 1'b0;
        write_enable   = 1'b0;
        write_address  = 5'd0;
        write_data     = 32'h0;
        read_enable_a  = 1'b0;
        read_address_a = 5'd0;
        read_enable_b  = 1'b0;
        read_address_b = 5'd0;

        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd2);
        checkOutput("in_reset_a", read_data_a, 32'h0);
        checkOutput("in_reset_b", read_data_b, 32'h0);

        // Reset clear of a previously written register
        applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b0, 5'd0);
        checkOutput("r5_bypass", read_data_a, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
        checkOutput("r5_forced_zero_a", read_data_a, 32'h0);
        checkOutput("r5_forced_zero_b", read_data_b, 32'h0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
        checkOutput("r5_after_reset", read_data_a, 32'h0);

        // Write then read on both ports
        applyStimulus(1'b1, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd7, 1'b0, 5'd7);
        checkOutput("r7_disabled_a", read_data_a, 32'h0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
        checkOutput("r7_read_a", read_data_a, 32'h12345678);
        checkOutput("r7_read_b", read_data_b, 32'h12345678);

        // Bypass of a new value over a stale entry
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h11111111, 1'b0, 5'd0, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h22222222, 1'b1, 5'd3, 1'b1, 5'd3);
        checkOutput("r3_bypass_a", read_data_a, 32'h22222222);
        checkOutput("r3_bypass_b", read_data_b, 32'h22222222);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0);
        checkOutput("r3_stored", read_data_a, 32'h22222222);

        // Register zero ignores writes and never bypasses
        applyStimulus(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0);
        checkOutput("r0_same_cycle", read_data_a, 32'h0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd0);
        checkOutput("r0_next_cycle", read_data_b, 32'h0);

        // Read enable gating per port
        applyStimulus(1'b1, 1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 1'b1, 5'd9);
        checkOutput("r9_gated_a", read_data_a, 32'h0);
        checkOutput("r9_enabled_b", read_data_b, 32'hCAFEF00D);

        // Reset on the same edge as a write cancels it
        applyStimulus(1'b0, 1'b1, 5'd4, 32'hAAAA5555, 1'b1, 5'd4, 1'b1, 5'd9);
        checkOutput("r4_in_reset", read_data_a, 32'h0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd9);
        checkOutput("r4_cancelled", read_data_a, 32'h0);
        checkOutput("r9_cleared", read_data_b, 32'h0);

        // Top register boundary
        applyStimulus(1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b1, 5'd30);
        checkOutput("r31_read", read_data_a, 32'hFFFFFFFF);
        checkOutput("r30_untouched", read_data_b, 32'h0);

        // Mixed traffic checked by the model only
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end

        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clock);
        #1;
        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
